// File: rtl/onehot_pulse_decoder_pkg.sv
// onehot_pulse_decoder_pkg: shared state encoding and limits for the pulse decoder
package onehot_pulse_decoder_pkg;
  typedef enum logic {IDLE, DRIVE} dec_state_t;
  localparam int HOLD_MAX = 255;
endpackage

// File: rtl/onehot_pulse_decoder_if.sv
// onehot_pulse_decoder_if: request handshake and one-hot output bundle
// master: request source (drives in_valid/idx); slave: the decoder.
// err exists only when DEC_OOR_ERR_EN is defined.
interface onehot_pulse_decoder_if #(
  parameter int N = 4,
  parameter int W = $clog2(N)
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] idx;
  logic [N-1:0] y;
  logic         busy;
`ifdef DEC_OOR_ERR_EN
  logic         err;
  modport master (output in_valid, idx, input in_ready, y, busy, err);
  modport slave  (input in_valid, idx, output in_ready, y, busy, err);
`else
  modport master (output in_valid, idx, input in_ready, y, busy);
  modport slave  (input in_valid, idx, output in_ready, y, busy);
`endif
endinterface

// File: rtl/onehot_pulse_decoder_hold_counter.sv
// hold_counter: reloadable down-counter flagging the last cycle of a pulse
// ports: clk, rst (async, active high), load (reload HOLD-1), dec (count down), zero (count is 0)
module hold_counter #(
  parameter int HOLD = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero
);
  localparam int CW = $clog2(HOLD + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (load) cnt <= CW'(HOLD - 1);
    else if (dec) cnt <= cnt - CW'(1);
  assign zero = (cnt == '0);
endmodule

// File: rtl/onehot_pulse_decoder.sv
// onehot_pulse_decoder: registered binary-to-one-hot decoder emitting a HOLD-cycle pulse per request
// ports: clk, rst (async, active high), bus (onehot_pulse_decoder_if.slave: in_valid/in_ready/idx in, y/busy out)
// DEC_OOR_ERR_EN: adds a sticky bus.err set when an out-of-range idx is accepted.
module onehot_pulse_decoder
  import onehot_pulse_decoder_pkg::*;
#(
  parameter int N    = 4,
  parameter int W    = $clog2(N),
  parameter int HOLD = 1
) (
  input logic clk,
  input logic rst,
  onehot_pulse_decoder_if.slave bus
);
  dec_state_t   state, state_n;
  logic [N-1:0] y_q;
  logic         accept, in_rng, zero;
  assign accept = bus.in_valid & bus.in_ready;
  assign in_rng = accept & (32'(bus.idx) < N);
  hold_counter #(.HOLD(HOLD)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (in_rng),
    .dec  (state == DRIVE && !zero),
    .zero (zero)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = (state == IDLE) ? (in_rng ? DRIVE : IDLE) : (zero ? IDLE : DRIVE);
  always_comb begin
    bus.in_ready = (state == IDLE);
    bus.busy     = (state == DRIVE);
  end
  // y is only ever loaded from IDLE, so clearing it on leaving DRIVE
  // guarantees an all-zero cycle between consecutive pulses.
  always_ff @(posedge clk or posedge rst)
    if (rst) y_q <= '0;
    else if (in_rng) y_q <= N'(1) << bus.idx;
    else if (state == DRIVE && zero) y_q <= '0;
  assign bus.y = y_q;
`ifdef DEC_OOR_ERR_EN
  logic err_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) err_q <= 1'b0;
    else if (accept && !in_rng) err_q <= 1'b1;
  assign bus.err = err_q;
`endif
endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// tb_onehot_pulse_decoder: self-checking bench for two decoder configurations
module tb_onehot_pulse_decoder;
  localparam int N0 = 4, H0 = 1;
  localparam int N1 = 5, H1 = 3;
  logic clk = 0, rst = 1;
  int   n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  onehot_pulse_decoder_if #(.N(N0)) b0 ();
  onehot_pulse_decoder_if #(.N(N1)) b1 ();
  onehot_pulse_decoder #(.N(N0), .HOLD(H0)) u0 (.clk(clk), .rst(rst), .bus(b0));
  onehot_pulse_decoder #(.N(N1), .HOLD(H1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  typedef struct {
    bit         v;
    logic [1:0] idx;
    logic [3:0] y;
    bit         rdy;
  } vec_t;
  vec_t tbl[10];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int t0, t1, tg0, tg1, e;
    bit err_m;
    logic [31:0] ey;
    b0.in_valid = 0; b0.idx = '0;
    b1.in_valid = 0; b1.idx = '0;
    // table for u0 (N=4, HOLD=1): inputs before an edge, outputs after it
    tbl[0] = '{1, 2'd2, 4'b0100, 0};
    tbl[1] = '{0, 2'd0, 4'b0000, 1};
    tbl[2] = '{0, 2'd2, 4'b0000, 1};
    tbl[3] = '{1, 2'd3, 4'b1000, 0};
    tbl[4] = '{1, 2'd1, 4'b0000, 1};
    tbl[5] = '{1, 2'd1, 4'b0010, 0};
    tbl[6] = '{0, 2'd0, 4'b0000, 1};
    tbl[7] = '{1, 2'd0, 4'b0001, 0};
    tbl[8] = '{1, 2'd0, 4'b0000, 1};
    tbl[9] = '{0, 2'd3, 4'b0000, 1};
    step();
    step();
    chk("reset_y0", 32'(b0.y), 0);
    chk("reset_busy0", 32'(b0.busy), 0);
    chk("reset_y1", 32'(b1.y), 0);
    chk("reset_rdy1", 32'(b1.in_ready), 1);
`ifdef DEC_OOR_ERR_EN
    chk("reset_err1", 32'(b1.err), 0);
`endif
    rst = 0;
    step();
    chk("ready_after_reset", 32'(b0.in_ready), 1);
    foreach (tbl[i]) begin
      b0.in_valid = tbl[i].v;
      b0.idx = tbl[i].idx;
      step();
      chk($sformatf("tbl%0d_y", i), 32'(b0.y), 32'(tbl[i].y));
      chk($sformatf("tbl%0d_rdy", i), 32'(b0.in_ready), 32'(tbl[i].rdy));
    end
    b0.in_valid = 0;
    // long hold on u1 (HOLD=3); idx change during DRIVE must be ignored
    b1.in_valid = 1; b1.idx = 3'd0;
    step();
    chk("hold_c1_y", 32'(b1.y), 1);
    chk("hold_c1_rdy", 32'(b1.in_ready), 0);
    b1.in_valid = 0;
    step();
    chk("hold_c2_y", 32'(b1.y), 1);
    chk("hold_c2_busy", 32'(b1.busy), 1);
    b1.in_valid = 1; b1.idx = 3'd4;
    step();
    chk("hold_c3_y", 32'(b1.y), 1);
    chk("hold_c3_busy", 32'(b1.busy), 1);
    b1.in_valid = 0;
    step();
    chk("hold_end_y", 32'(b1.y), 0);
    chk("hold_end_rdy", 32'(b1.in_ready), 1);
    chk("hold_end_busy", 32'(b1.busy), 0);
    // out-of-range requests on N=5
    b1.in_valid = 1; b1.idx = 3'd6;
    step();
    chk("oor6_y", 32'(b1.y), 0);
    chk("oor6_rdy", 32'(b1.in_ready), 1);
`ifdef DEC_OOR_ERR_EN
    chk("oor6_err", 32'(b1.err), 1);
`endif
    b1.idx = 3'd5;
    step();
    chk("oor5_y", 32'(b1.y), 0);
    b1.in_valid = 0;
    step();
    chk("oor_after_rdy", 32'(b1.in_ready), 1);
`ifdef DEC_OOR_ERR_EN
    chk("oor_err_sticky", 32'(b1.err), 1);
`endif
    // asynchronous reset in the middle of a pulse
    b1.in_valid = 1; b1.idx = 3'd1;
    step();
    b1.in_valid = 0;
    step();
    chk("pre_rst_y", 32'(b1.y), 2);
    #2 rst = 1;
    #1;
    chk("async_rst_y", 32'(b1.y), 0);
    chk("async_rst_rdy", 32'(b1.in_ready), 1);
`ifdef DEC_OOR_ERR_EN
    chk("async_rst_err", 32'(b1.err), 0);
`endif
    step();
    rst = 0;
    b0.in_valid = 1; b0.idx = 2'd3;
    b1.in_valid = 1; b1.idx = 3'd3;
    step();
    chk("post_rst_y0", 32'(b0.y), 8);
    chk("post_rst_y1", 32'(b1.y), 8);
    b0.in_valid = 0; b1.in_valid = 0;
    repeat (4) step();
    // randomized phase against a timeline model: accept at edge t means
    // y high after edges t..t+HOLD-1, ready again after edge t+HOLD
    t0 = -100; t1 = -100; tg0 = 0; tg1 = 0; e = 0; err_m = 0;
    for (int k = 0; k < 400; k++) begin
      b0.in_valid = $urandom_range(0, 1);
      b0.idx = 2'($urandom_range(0, 3));
      b1.in_valid = $urandom_range(0, 1);
      b1.idx = 3'($urandom_range(0, 7));
      @(posedge clk);
      if (b0.in_valid && e >= t0 + H0 + 1) begin
        t0 = e; tg0 = int'(b0.idx);
      end
      if (b1.in_valid && e >= t1 + H1 + 1) begin
        if (int'(b1.idx) < N1) begin
          t1 = e; tg1 = int'(b1.idx);
        end else err_m = 1;
      end
      #1;
      ey = (e >= t0 && e <= t0 + H0 - 1) ? 32'(1) << tg0 : 0;
      chk("rnd_y0", 32'(b0.y), ey);
      chk("rnd_rdy0", 32'(b0.in_ready), 32'(e >= t0 + H0));
      ey = (e >= t1 && e <= t1 + H1 - 1) ? 32'(1) << tg1 : 0;
      chk("rnd_y1", 32'(b1.y), ey);
      chk("rnd_busy1", 32'(b1.busy), 32'(e < t1 + H1));
`ifdef DEC_OOR_ERR_EN
      chk("rnd_err1", 32'(b1.err), 32'(err_m));
`endif
      e++;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/onehot_pulse_decoder.md
# onehot_pulse_decoder

Registered binary-to-one-hot decoder with a valid/ready handshake. Accepts a binary index and drives exactly one output line high for a fixed number of cycles, then releases it. Always leaves at least one all-zero cycle between pulses (break-before-make). It is the companion of the priority encoder: the encoder turns a request vector into an index, and this block turns an index back into a timed one-hot select line.

## Interface
Parameters:
- `N`, default 4: number of one-hot outputs; legal range 2..256.
- `W`, default `$clog2(N)`: index width. Derived from `N`; not overridden.
- `HOLD`, default 1: number of cycles the selected line stays high; legal range 1..255.

Ports:
- `clk` input, 1 bit: the single clock. All state changes on the rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `in_valid` input, 1 bit: `idx` holds a request.
- `in_ready` output, 1 bit: block can accept a request this cycle.
- `idx` input, `W` bits: binary index of the line to assert.
- `y` output, `N` bits: one-hot output, registered; either all zeros or exactly one bit set.
- `busy` output, 1 bit: a pulse is in progress.
- `err` output, 1 bit: sticky out-of-range flag. Present only when `DEC_OOR_ERR_EN` is defined.

## Operation
States: `IDLE`, `DRIVE`. Reset state is `IDLE`.

Reset values:
- `y` = 0, `busy` = 0, `err` = 0.
- `in_ready` = 1 once `rst` is deasserted.

Rules:
- `in_ready` = (state == `IDLE`), combinational from the state register.
- **Accept:** a request is accepted on a rising edge where `in_valid & in_ready` is true.
- **IDLE, accept of an in-range request (`idx < N`):**
  - load `y` with `1 << idx`;
  - load the hold counter with `HOLD-1`;
  - go to `DRIVE`; `busy` = 1.
- **IDLE, accept of an out-of-range request (`idx >= N`, possible only when `N` is not a power of 2):**
  - the request is consumed;
  - `y` stays 0 and the state stays `IDLE`.
- **DRIVE:**
  - if counter ≠ 0: decrement the counter; `y` is held.
  - if counter == 0: `y` ← 0, `busy` ← 0, go to `IDLE`.
- `in_valid` is ignored while in `DRIVE`. No queueing: the source must hold `in_valid` and `idx` until it sees `in_ready`.
- Hold counter width is `$clog2(HOLD+1)` and it is unsigned. It never wraps, because it is reloaded before each use.
- `idx` changing while `in_ready` = 0 has no effect.
- **Reset mid-pulse:** `y` clears to 0 immediately (asynchronously) and the state returns to `IDLE`.

## Timing
- Latency: request accepted at edge t → `y` is high from t+1 through t+HOLD inclusive.
- At t+HOLD+1, `y` = 0 and `in_ready` = 1.
- Earliest next accept is edge t+HOLD+1, so `y` is high again at the earliest at t+HOLD+2.
- This guarantees at least one all-zero cycle between pulses.
- Maximum throughput: one request per HOLD+1 cycles.
- `HOLD` = 1: single-cycle pulse, one request every 2 cycles.

## Configuration
- Macro: `DEC_OOR_ERR_EN`.
- **Defined:**
  - port `err` exists;
  - `err` is set on the edge that accepts an out-of-range `idx`;
  - `err` stays set until `rst`;
  - the request is still dropped and `y` stays 0.
- **Undefined:**
  - no `err` port and no `err` flop;
  - an out-of-range request is dropped silently.

## Structure
- Shared package `onehot_pulse_decoder_pkg`:
  - state enum `dec_state_t` {`IDLE`, `DRIVE`};
  - constant `HOLD_MAX` = 255.
- One sub-module, `hold_counter`:
  - parameter `HOLD`;
  - inputs `load`, `dec`;
  - output `zero`;
  - async active-high reset to 0.
- The top level contains the FSM and the `y` register.

## Test plan
1. **Basic pulse.** Setup: `N`=4, `HOLD`=1. Stimulus: `idx`=2 with `in_valid` held for one cycle. Required response:
   - `y` = 4'b0100 for exactly 1 cycle, then 0;
   - `in_ready` low for exactly 1 cycle.
2. **Longer hold.** Setup: `HOLD`=3. Stimulus: `idx`=0. Required response:
   - `y` = 4'b0001 for 3 cycles;
   - `busy` high for 3 cycles;
   - `in_ready` returns on the 4th cycle.
3. **Back-to-back requests.** Setup: `HOLD`=1. Stimulus: `in_valid` held high continuously, `idx` sequence 3, 1. Required response:
   - `y` sequence is 1000, 0000, 0010, 0000;
   - no cycle ever has two bits set.
4. **Out-of-range index.** Setup: `N`=5, `W`=3. Stimulus: `idx`=6. Required response:
   - `y` stays 0 and `in_ready` stays 1;
   - with `DEC_OOR_ERR_EN` defined, `err` = 1 from the next cycle until `rst`.
5. **Reset mid-pulse.** Setup: `HOLD`=4. Stimulus: `idx`=1 accepted, then assert `rst` 2 cycles later. Required response:
   - `y` = 0 without waiting for a clock edge;
   - after `rst` deasserts, `in_ready` = 1 and a new request `idx`=3 produces `y` = 4'b1000.
6. **Ignored input during DRIVE.** Setup: `HOLD`=2. Stimulus: change `idx` while in `DRIVE`. Required response:
   - `y` holds the originally accepted one-hot value for the full 2 cycles.
